// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the serial lane blocks: FSM state encoding and
// the bit-counter width derived from the word width.
package megav_serial_pkg;

  typedef enum logic {SER_IDLE = 1'b0, SER_SHIFT = 1'b1} ser_state_t;

  function automatic int ser_cnt_w(input int bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_counter.sv
// Down-counter of remaining beats: load has priority, decrement sticks at zero,
// and zero flags the final beat of a word.
module bit_counter_down
  import megav_serial_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter: one word in over valid/ready, one bit per
// accepted beat out, with out_last on the final bit and zero-bubble reload.
module piso_serializer
  import megav_serial_pkg::*;
#(
  parameter int BITS      = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic            out_last
);

  localparam int             CW      = ser_cnt_w(BITS);
  localparam logic [CW-1:0]  LOAD_V  = CW'(BITS - 1);
  localparam int             OUT_IDX = LSB_FIRST ? 0 : BITS - 1;

  ser_state_t      state;
  logic [BITS-1:0] shreg;
  logic            cnt_zero;
  logic            beat;
  logic            final_beat;
  logic            accept;

  assign out_valid  = (state == SER_SHIFT);
  assign beat       = out_valid & out_ready;
  assign out_last   = out_valid & cnt_zero;
  assign final_beat = beat & out_last;
  // Ready on the final beat lets the next word follow with no idle cycle.
  assign in_ready   = (state == SER_IDLE) | final_beat;
  assign accept     = in_valid & in_ready;
  assign out_bit    = out_valid & shreg[OUT_IDX];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SER_IDLE;
      shreg <= '0;
    end else if (accept) begin
      state <= SER_SHIFT;
      shreg <= in_data;
    end else if (beat) begin
      shreg <= LSB_FIRST ? {1'b0, shreg[BITS-1:1]} : {shreg[BITS-2:0], 1'b0};
      if (final_beat) state <= SER_IDLE;
    end
  end

  bit_counter_down #(
    .WIDTH(CW)
  ) u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept),
    .load_value(LOAD_V),
    .dec       (beat),
    .zero      (cnt_zero)
  );

`ifdef FORMAL
  a_last_valid: assert property (@(posedge clk) disable iff (!reset_n) out_last |-> out_valid);
  a_bit_quiet:  assert property (@(posedge clk) disable iff (!reset_n) !out_valid |-> !out_bit);
  a_accept:     assert property (@(posedge clk) disable iff (!reset_n)
                                 (in_ready && in_valid) |=> (state == SER_SHIFT));
`endif

endmodule
